lsu: RTL

Load/store stage between the execute stage and write-back in the npc core. Accepts one instruction per handshake from the execute stage, issues at most one memory request on a single-outstanding request/response bus, extends load data, and hands the result to write-back via a valid/ready handshake. Non-memory instructions bypass the bus and pass through after one cycle.

---
 rtl/lsu.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu - load/store stage between execute and write-back.
//
// Accepts one instruction per handshake from execute. For a load or store it
// issues exactly one request on a single-outstanding request/response bus.
// For a load it masks the returned data and extends it. The result is then
// handed to write-back over a valid/ready handshake. Instructions that are
// neither loads nor stores skip the bus and emerge one cycle later.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   lsu_receive_valid            execute holds a valid instruction
//   lsu_send_ready               upstream ready (high only in IDLE)
//   alu_result_input             address for loads/stores, result otherwise
//   rsb_input, wmask_input       store data and store byte mask
//   ren_input, wen_input         load / store flags (store wins if both)
//   rmask_input                  load width mask (FF, FFFF, FFFFFFFF)
//   memory_read_signed_input     sign-extend load data
//   reg_write_en_input, rd_input, pc_next_input   forwarded to write-back
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask   request
//   mem_rsp_valid, mem_rdata     response (rdata right-aligned)
//   lsu_send_valid, lsu_receive_ready, lsu_result   result to write-back
//   reg_write_en, rd, pc_next    registered forwarded fields
// ---------------------------------------------------------------------------
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_receive_valid,
    output logic        lsu_send_ready,
    input  logic [31:0] alu_result_input,
    input  logic [31:0] rsb_input,
    input  logic        ren_input,
    input  logic        wen_input,
    input  logic [7:0]  wmask_input,
    input  logic [31:0] rmask_input,
    input  logic        memory_read_signed_input,
    input  logic        reg_write_en_input,
    input  logic [4:0]  rd_input,
    input  logic [31:0] pc_next_input,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        lsu_send_valid,
    input  logic        lsu_receive_ready,
    output logic [31:0] lsu_result,
    output logic        reg_write_en,
    output logic [4:0]  rd,
    output logic [31:0] pc_next
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    // Load formatting controls captured with the instruction.
    logic [31:0] rmask_r;
    logic        signed_r;

    // Next values of every register.
    logic        mem_req_valid_s;
    logic [31:0] mem_addr_s;
    logic        mem_wen_s;
    logic [31:0] mem_wdata_s;
    logic [7:0]  mem_wmask_s;
    logic        lsu_send_valid_s;
    logic [31:0] lsu_result_s;
    logic        reg_write_en_s;
    logic [4:0]  rd_s;
    logic [31:0] pc_next_s;
    logic [31:0] rmask_s;
    logic        signed_s;

    // Mask the load data to its width, then sign-extend byte and halfword
    // loads when requested. Word and unsigned loads are only masked.
    function automatic logic [31:0] load_extend(input logic [31:0] data,
                                                input logic [31:0] mask,
                                                input logic        sgn);
        logic [31:0] masked;
        masked = data & mask;
        if (sgn && (mask == 32'h0000_00FF)) begin
            load_extend = {{24{masked[7]}}, masked[7:0]};
        end else if (sgn && (mask == 32'h0000_FFFF)) begin
            load_extend = {{16{masked[15]}}, masked[15:0]};
        end else begin
            load_extend = masked;
        end
    endfunction

    // Upstream may hand over an instruction only while the stage is empty.
    assign lsu_send_ready = (state_r == ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lsu_receive_valid) begin
                    if (ren_input || wen_input) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (lsu_send_valid && lsu_receive_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; every field holds unless the
    // current state updates it.
    always_comb begin
        mem_req_valid_s  = mem_req_valid;
        mem_addr_s       = mem_addr;
        mem_wen_s        = mem_wen;
        mem_wdata_s      = mem_wdata;
        mem_wmask_s      = mem_wmask;
        lsu_send_valid_s = lsu_send_valid;
        lsu_result_s     = lsu_result;
        reg_write_en_s   = reg_write_en;
        rd_s             = rd;
        pc_next_s        = pc_next;
        rmask_s          = rmask_r;
        signed_s         = signed_r;
        case (state_r)
            ST_IDLE: begin
                if (lsu_receive_valid) begin
                    // mem_addr doubles as the saved ALU result for stores.
                    mem_req_valid_s = ren_input | wen_input;
                    mem_addr_s      = alu_result_input;
                    mem_wen_s       = wen_input;
                    mem_wdata_s     = wen_input ? rsb_input : 32'h0000_0000;
                    mem_wmask_s     = wen_input ? wmask_input : 8'h00;
                    lsu_result_s    = alu_result_input;
                    reg_write_en_s  = reg_write_en_input;
                    rd_s            = rd_input;
                    pc_next_s       = pc_next_input;
                    rmask_s         = rmask_input;
                    signed_s        = memory_read_signed_input;
                end else begin
                    lsu_send_valid_s = 1'b0;
                end
                lsu_send_valid_s = 1'b0;
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_s = 1'b0;
                end else begin
                    mem_req_valid_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    if (mem_wen) begin
                        lsu_result_s = mem_addr;
                    end else begin
                        lsu_result_s = load_extend(mem_rdata, rmask_r, signed_r);
                    end
                    lsu_send_valid_s = 1'b1;
                end else begin
                    lsu_send_valid_s = 1'b0;
                end
            end
            ST_DONE: begin
                // A bypass instruction enters DONE with valid still low and
                // raises it one cycle later; a memory result arrives valid.
                if (lsu_send_valid) begin
                    if (lsu_receive_ready) begin
                        lsu_send_valid_s = 1'b0;
                    end else begin
                        lsu_send_valid_s = 1'b1;
                    end
                end else begin
                    lsu_send_valid_s = 1'b1;
                end
            end
            default: begin
                mem_req_valid_s  = 1'b0;
                lsu_send_valid_s = 1'b0;
            end
        endcase
    end

    // Output and capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_valid  <= 1'b0;
            mem_addr       <= 32'h0000_0000;
            mem_wen        <= 1'b0;
            mem_wdata      <= 32'h0000_0000;
            mem_wmask      <= 8'h00;
            lsu_send_valid <= 1'b0;
            lsu_result     <= 32'h0000_0000;
            reg_write_en   <= 1'b0;
            rd             <= 5'd0;
            pc_next        <= 32'h0000_0000;
            rmask_r        <= 32'h0000_0000;
            signed_r       <= 1'b0;
        end else begin
            mem_req_valid  <= mem_req_valid_s;
            mem_addr       <= mem_addr_s;
            mem_wen        <= mem_wen_s;
            mem_wdata      <= mem_wdata_s;
            mem_wmask      <= mem_wmask_s;
            lsu_send_valid <= lsu_send_valid_s;
            lsu_result     <= lsu_result_s;
            reg_write_en   <= reg_write_en_s;
            rd             <= rd_s;
            pc_next        <= pc_next_s;
            rmask_r        <= rmask_s;
            signed_r       <= signed_s;
        end
    end

endmodule
